// File: rtl/gpio_in_cond_if.sv
// Pad-input conditioner bus: raw pad levels and per-channel controls in,
// conditioned levels and sticky edge status out.
interface gpio_in_cond_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DB_BITS = 4
);
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   db_en;
    logic [DB_BITS-1:0] db_len;
    logic [WIDTH-1:0]   rise_en;
    logic [WIDTH-1:0]   fall_en;
    logic [WIDTH-1:0]   irq_clr;
    logic [WIDTH-1:0]   in_val;
    logic [WIDTH-1:0]   irq_stat;
    logic               irq;

    modport master (
        output y, db_en, db_len, rise_en, fall_en, irq_clr,
        input  in_val, irq_stat, irq
    );

    modport slave (
        input  y, db_en, db_len, rise_en, fall_en, irq_clr,
        output in_val, irq_stat, irq
    );
endinterface

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: 2-flop synchronizer, optional per-channel debounce,
// and sticky rising/falling edge status with a combined interrupt.
module gpio_in_cond #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DB_BITS = 4
) (
    input logic           clk,
    input logic           rst_n,
    gpio_in_cond_if.slave bus
);
    logic [WIDTH-1:0]              s1_q, s2_q;
    logic [WIDTH-1:0]              in_val_q, in_val_d;
    logic [WIDTH-1:0]              irq_stat_q, irq_stat_d;
    logic [WIDTH-1:0][DB_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]              rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            in_val_q   <= '0;
            irq_stat_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= bus.y;
            s2_q       <= s1_q;
            in_val_q   <= in_val_d;
            irq_stat_q <= irq_stat_d;
            cnt_q      <= cnt_d;
        end
    end

    // The count holds the number of earlier consecutive mismatching cycles, so
    // reaching db_len means this cycle is mismatch db_len+1. Using >= lets a
    // shortened db_len take effect on the very next compare.
    always_comb begin
        in_val_d = in_val_q;
        cnt_d    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != in_val_q[i]) begin
                if (!bus.db_en[i] || (cnt_q[i] >= bus.db_len)) begin
                    in_val_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise       = in_val_d & ~in_val_q;
        fall       = ~in_val_d & in_val_q;
        irq_stat_d = (irq_stat_q & ~bus.irq_clr)
                   | (rise & bus.rise_en)
                   | (fall & bus.fall_en);
    end

    assign bus.in_val   = in_val_q;
    assign bus.irq_stat = irq_stat_q;
    assign bus.irq      = |irq_stat_q;
endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 Parameter WIDTH, default 8: number of pad input channels.
REQ-002 Parameter DB_BITS, default 4: width of the debounce length field.
REQ-003 clk  input  1: single block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 y  input  WIDTH: pad receive outputs, asynchronous to clk.
REQ-006 db_en  input  WIDTH: per-channel debounce enable.
REQ-007 db_len  input  DB_BITS: shared debounce length in cycles, minus 1.
REQ-008 rise_en  input  WIDTH: per-channel rising-edge interrupt enable.
REQ-009 fall_en  input  WIDTH: per-channel falling-edge interrupt enable.
REQ-010 irq_clr  input  WIDTH: per-channel clear of irq_stat, one-cycle write-1-to-clear pulse.
REQ-011 in_val  output  WIDTH: conditioned, registered pad level.
REQ-012 irq_stat  output  WIDTH: sticky per-channel edge status.
REQ-013 irq  output  1: combinational OR of all irq_stat bits.

Function
REQ-014 Each y bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 db_en[i]=0: in_val[i] SHALL load s2[i] every cycle, i.e. a y change appears on in_val at the 3rd rising clk edge after it.
REQ-016 db_en[i]=1: each channel SHALL keep a DB_BITS counter, cleared whenever s2[i]==in_val[i].
REQ-017 While s2[i]!=in_val[i]: counter increments each cycle; when counter==db_len the same edge loads s2[i] into in_val[i] and clears the counter.
REQ-018 Net effect: in_val[i] changes only after s2[i] has differed for db_len+1 consecutive cycles; db_len=0 is equivalent to db_en=0.
REQ-019 Any glitch returning s2[i] to in_val[i] before the count completes SHALL restart the count from 0.
REQ-020 db_len or db_en changing mid-count SHALL take effect on the next compare; no count is preserved across a db_en 1->0 change (counter held at 0 while db_en=0).
REQ-021 Rising event[i] = next in_val[i]=1 while current in_val[i]=0; falling event is the converse.
REQ-022 An event with the matching enable set SHALL set irq_stat[i] on the same edge that updates in_val[i].
REQ-023 irq_stat[i] SHALL remain set until irq_clr[i]=1 is sampled; it then clears on that edge.
REQ-024 Simultaneous set event and irq_clr on one channel: set wins, irq_stat[i]=1.
REQ-025 Disabling rise_en/fall_en SHALL NOT clear an already-set irq_stat bit.
REQ-026 Channels SHALL be fully independent; no cross-channel priority or ordering.

Reset
REQ-027 rst_n=0 SHALL immediately clear s1, s2, in_val, all debounce counters and irq_stat; irq=0.
REQ-028 After reset release, a pad held high SHALL produce a normal rising event (irq_stat set if rise_en); software clears it.
REQ-029 Reset asserted mid-debounce SHALL abort the count; no event is generated for the aborted transition.

Verification
REQ-030 db_en=0, rise_en[0]=1, y[0] 0->1 -> in_val[0]=1 and irq_stat[0]=1 on 3rd clk edge, irq=1.
REQ-031 db_en[1]=1, db_len=3, y[1] high for 3 cycles then low -> in_val[1] stays 0, irq_stat[1]=0; held 4+ cycles -> in_val[1]=1 at s2 change +4 edges.
REQ-032 fall_en[2]=1, rise_en[2]=0, y[2] 0->1->0 -> only the falling edge sets irq_stat[2]; irq_clr[2] pulse -> irq_stat[2]=0, irq=0.
REQ-033 irq_clr[3] asserted on same edge as a rising event on channel 3 -> irq_stat[3]=1 afterwards.
REQ-034 rst_n pulsed low mid-count (db_len=7, count at 4) -> all outputs 0 during reset; y held high after release -> rising event after 8 cycles of stable s2.
REQ-035 All WIDTH channels toggled together with mixed enables -> irq_stat equals (rise_en & rising) | (fall_en & falling) bitwise.
